// File: rtl/sound_player_if.sv
// Sound path handshake between game control / arbiter (master) and the sound player (slave).
interface sound_player_if;
  logic [3:0] sound_code;
  logic       sound_start;
  logic       audio_out;
  logic       busy;
  logic [3:0] current_code;
  logic       done;

  modport master (
    output sound_code, sound_start,
    input  audio_out, busy, current_code, done
  );

  modport slave (
    input  sound_code, sound_start,
    output audio_out, busy, current_code, done
  );
endinterface

// File: rtl/sound_player.sv
// Three-note square-wave sequence player with ms timebase and busy/done status.
// Optional macro SOUND_PLAYER_PRIORITY_EN: spaceship sequence cannot be preempted by monster hit.
module sound_player #(
  parameter int          TICK_DIV            = 50000,
  parameter int          STEP_TICKS          = 80,
  parameter int          HP_WIDTH            = 17,
  parameter int          HP_A                = 28409,
  parameter int          HP_B                = 37922,
  parameter int          HP_C                = 56818,
  parameter int          HP_D                = 113636,
  parameter logic [3:0]  MONSTER_HIT_SOUND   = 4'b0001,
  parameter logic [3:0]  SPACESHIP_HIT_SOUND = 4'b1101
) (
  input  logic         clk,
  input  logic         resetN,
  sound_player_if.slave sp
);

  localparam int TW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
  localparam int SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

  localparam logic [TW-1:0]       TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_TICKS - 1);
  localparam logic [HP_WIDTH-1:0] HPA_L     = HP_WIDTH'(HP_A - 1);
  localparam logic [HP_WIDTH-1:0] HPB_L     = HP_WIDTH'(HP_B - 1);
  localparam logic [HP_WIDTH-1:0] HPC_L     = HP_WIDTH'(HP_C - 1);
  localparam logic [HP_WIDTH-1:0] HPD_L     = HP_WIDTH'(HP_D - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t              state_q, state_d;
  logic [1:0]          step_q, step_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [SW-1:0]       stc_q, stc_d;
  logic [HP_WIDTH-1:0] hp_q, hp_d;
  logic                audio_q, audio_d;
  logic [3:0]          code_q, code_d;
  logic                done_q, done_d;

  logic                code_valid;
  logic                blocked;
  logic                step_end;
  logic [HP_WIDTH-1:0] hp_cur;

  // Sequence ROM: last count value of the half-period counter per (code, step)
  function automatic logic [HP_WIDTH-1:0] hp_last(input logic [3:0] code, input logic [1:0] step);
    if (code == SPACESHIP_HIT_SOUND)
      return (step == 2'd0) ? HPC_L : HPD_L;
    case (step)
      2'd0:    return HPA_L;
      2'd1:    return HPB_L;
      default: return HPC_L;
    endcase
  endfunction

  assign code_valid = (sp.sound_code == MONSTER_HIT_SOUND) ||
                      (sp.sound_code == SPACESHIP_HIT_SOUND);

`ifdef SOUND_PLAYER_PRIORITY_EN
  assign blocked = (state_q == PLAY) && (code_q == SPACESHIP_HIT_SOUND) &&
                   (sp.sound_code == MONSTER_HIT_SOUND);
`else
  assign blocked = 1'b0;
`endif

  assign hp_cur = hp_last(code_q, step_q);

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    tick_d   = tick_q;
    stc_d    = stc_q;
    hp_d     = hp_q;
    audio_d  = audio_q;
    code_d   = code_q;
    done_d   = 1'b0;
    step_end = 1'b0;

    if (state_q == PLAY) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        if (stc_q == STEP_LAST) begin
          stc_d    = '0;
          step_end = 1'b1;
        end else begin
          stc_d = stc_q + 1'b1;
        end
      end else begin
        tick_d = tick_q + 1'b1;
      end

      // Step boundary silences the output and restarts the tone phase
      if (step_end) begin
        hp_d    = '0;
        audio_d = 1'b0;
        if (step_q == 2'd2) begin
          state_d = IDLE;
          step_d  = '0;
          code_d  = '0;
          done_d  = 1'b1;
        end else begin
          step_d = step_q + 1'b1;
        end
      end else if (hp_q == hp_cur) begin
        hp_d    = '0;
        audio_d = ~audio_q;
      end else begin
        hp_d = hp_q + 1'b1;
      end
    end

    // Start strobe overrides the natural progression, including completion
    if (sp.sound_start) begin
      if (sp.sound_code == 4'b0000) begin
        state_d = IDLE;
        step_d  = '0;
        tick_d  = '0;
        stc_d   = '0;
        hp_d    = '0;
        audio_d = 1'b0;
        code_d  = '0;
        done_d  = 1'b0;
      end else if (code_valid && !blocked) begin
        state_d = PLAY;
        step_d  = '0;
        tick_d  = '0;
        stc_d   = '0;
        hp_d    = '0;
        audio_d = 1'b0;
        code_d  = sp.sound_code;
        done_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      step_q  <= '0;
      tick_q  <= '0;
      stc_q   <= '0;
      hp_q    <= '0;
      audio_q <= 1'b0;
      code_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      tick_q  <= tick_d;
      stc_q   <= stc_d;
      hp_q    <= hp_d;
      audio_q <= audio_d;
      code_q  <= code_d;
      done_q  <= done_d;
    end
  end

  assign sp.audio_out    = audio_q;
  assign sp.busy         = (state_q == PLAY);
  assign sp.current_code = code_q;
  assign sp.done         = done_q;

endmodule

// File: tb/tb_sound_player.sv
// Directed bench for sound_player with shrunken timebase (8 cycles per note step).
module tb_sound_player;

  logic clk;
  logic resetN;
  int   checks;
  int   failures;
  int   dones;

  sound_player_if sp();

  sound_player #(
    .TICK_DIV   (4),
    .STEP_TICKS (2),
    .HP_WIDTH   (17),
    .HP_A       (3),
    .HP_B       (5),
    .HP_C       (7),
    .HP_D       (9)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .sp     (sp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle strobe; returns 1 time unit after the accepting edge
  task automatic start_pulse(input logic [3:0] code);
    sp.sound_code  = code;
    sp.sound_start = 1'b1;
    @(posedge clk);
    #1;
    sp.sound_start = 1'b0;
    sp.sound_code  = 4'b0000;
  endtask

  task automatic idle_outputs(input string tag);
    chk1({tag, "_busy"},  sp.busy, 1'b0);
    chk1({tag, "_audio"}, sp.audio_out, 1'b0);
    chk4({tag, "_code"},  sp.current_code, 4'b0000);
    chk1({tag, "_done"},  sp.done, 1'b0);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    resetN         = 1'b0;
    sp.sound_code  = 4'b0000;
    sp.sound_start = 1'b0;

    // 1. reset state
    #2;
    idle_outputs("t1_reset");
    tick(2);
    resetN = 1'b1;
    tick(2);
    idle_outputs("t1_post");

    // 2. monster hit: half periods 3,5,7; step end forces audio low
    start_pulse(4'b0001);
    chk1("t2_busy_start", sp.busy, 1'b1);
    chk4("t2_code", sp.current_code, 4'b0001);
    chk1("t2_audio_start", sp.audio_out, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      logic e;
      tick(1);
      e = (k >= 3 && k <= 5) || (k >= 13 && k <= 15) || (k == 23);
      chk1($sformatf("t2_audio_k%0d", k), sp.audio_out, e);
      chk1($sformatf("t2_done_k%0d", k), sp.done, (k == 24));
      chk1($sformatf("t2_busy_k%0d", k), sp.busy, (k != 24));
    end
    chk4("t2_code_end", sp.current_code, 4'b0000);
    tick(1);
    chk1("t2_done_single", sp.done, 1'b0);

    // 3. unknown code while idle is ignored
    start_pulse(4'b0101);
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      if (sp.done) dones++;
      chk1($sformatf("t3_busy_k%0d", k), sp.busy, 1'b0);
      chk1($sformatf("t3_audio_k%0d", k), sp.audio_out, 1'b0);
      tick(1);
    end
    chk4("t3_nodone", 4'(dones), 4'd0);

    // 4. preempt monster with spaceship after 10 cycles
    start_pulse(4'b0001);
    dones = 0;
    tick(9);
    if (sp.done) dones++;
    start_pulse(4'b1101);
    chk4("t4_code", sp.current_code, 4'b1101);
    chk1("t4_audio_start", sp.audio_out, 1'b0);
    for (int k = 1; k <= 28; k++) begin
      tick(1);
      if (sp.done) dones++;
      if (k <= 24)
        chk1($sformatf("t4_audio_k%0d", k), sp.audio_out, (k == 7));
      if (k == 24) begin
        chk1("t4_done_24", sp.done, 1'b1);
        chk1("t4_busy_24", sp.busy, 1'b0);
      end
    end
    chk4("t4_done_count", 4'(dones), 4'd1);

    // 5a. stop with code 0 mid-play
    start_pulse(4'b1101);
    tick(4);
    start_pulse(4'b0000);
    idle_outputs("t5_stop");
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (sp.done) dones++;
    end
    chk4("t5_stop_nodone", 4'(dones), 4'd0);

    // 5b. async reset mid step 1 while the output is high
    start_pulse(4'b0001);
    tick(14);
    chk1("t5_audio_before_rst", sp.audio_out, 1'b1);
    chk1("t5_busy_before_rst", sp.busy, 1'b1);
    resetN = 1'b0;
    #1;
    idle_outputs("t5_reset");
    tick(2);
    resetN = 1'b1;
    tick(1);
    idle_outputs("t5_post_reset");

    // 6. monster start four cycles into spaceship
    start_pulse(4'b1101);
    tick(3);
    start_pulse(4'b0001);
    dones = 0;
`ifdef SOUND_PLAYER_PRIORITY_EN
    chk4("t6_code_kept", sp.current_code, 4'b1101);
    for (int k = 5; k <= 26; k++) begin
      tick(1);
      if (sp.done) dones++;
      if (k == 24) chk1("t6_done_24", sp.done, 1'b1);
    end
`else
    chk4("t6_code_restart", sp.current_code, 4'b0001);
    for (int k = 1; k <= 26; k++) begin
      tick(1);
      if (sp.done) dones++;
      if (k == 3) chk1("t6_audio_3", sp.audio_out, 1'b1);
      if (k == 24) chk1("t6_done_24", sp.done, 1'b1);
    end
`endif
    chk4("t6_done_count", 4'(dones), 4'd1);
    idle_outputs("t6_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
